cgra_config_loader: RTL and testbench

- Host-side driver for the CGRA configuration-load and execution-start interface.
- Accepts PE configuration entries from a host over a valid/ready stream and buffers them in a small FIFO.
- Replays the entries as single-cycle write_config_data pulses with row/column/index/op/const fields.
- After the last entry of a batch has been written, pulses start_exec with mapping_context_max_id set to the highest context index loaded.

---
 rtl/cgra_config_loader.sv | 148 ++++++++++++++
 tb/tb_cgra_config_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader.sv
// Host-side CGRA configuration loader. Host entries are buffered in a small
// FIFO, replayed as single-cycle write_config_data strobes, and each batch is
// closed with a start_exec pulse carrying the highest context index written.
module cgra_config_loader #(
  parameter int PE_ROW_SIZE             = 4,
  parameter int PE_COLUMN_SIZE          = 4,
  parameter int PE_ROW_BIT_LENGTH       = 2,
  parameter int PE_COLUMN_BIT_LENGTH    = 2,
  parameter int INPUT_NUM_BIT_LENGTH    = 3,
  parameter int OPERATION_BIT_LENGTH    = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int FIFO_DEPTH              = 4
)(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PE_ROW_BIT_LENGTH-1:0]       in_row,
  input  logic [PE_COLUMN_BIT_LENGTH-1:0]    in_column,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_index_1,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_index_2,
  input  logic [OPERATION_BIT_LENGTH-1:0]    in_op,
  input  logic [DATA_WIDTH-1:0]              in_const,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] in_context,
  input  logic                               in_last,
  output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               cfg_error
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [PE_ROW_BIT_LENGTH-1:0]       row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    col;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    idx1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    idx2;
    logic [OPERATION_BIT_LENGTH-1:0]    op;
    logic [DATA_WIDTH-1:0]              cst;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx;
    logic                               last;
  } entry_t;

  typedef enum logic {LOAD, START} state_t;

  entry_t                             mem [FIFO_DEPTH];
  entry_t                             in_entry, head;
  logic [AW:0]                        wr_ptr, rd_ptr;
  logic                               full, empty, push, pop, in_range;
  state_t                             state, state_nxt;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] acc;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign in_entry = '{row: in_row, col: in_column, idx1: in_input_index_1,
                      idx2: in_input_index_2, op: in_op, cst: in_const,
                      ctx: in_context, last: in_last};
  assign head     = mem[rd_ptr[AW-1:0]];
  assign in_range = (int'(head.row) < PE_ROW_SIZE) && (int'(head.col) < PE_COLUMN_SIZE);
  assign busy     = !empty || (state != LOAD);

  // Entry storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next state and pop: drain one entry per cycle in LOAD, pause one cycle in START.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      LOAD: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.last) state_nxt = START;
        end
      end
      START:   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Registered CGRA-side outputs; dropped entries leave config_* untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_PE_row_index     <= '0;
      config_PE_column_index  <= '0;
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_op               <= '0;
      config_const_data       <= '0;
      config_index            <= '0;
      write_config_data       <= 1'b0;
      start_exec              <= 1'b0;
      mapping_context_max_id  <= '0;
      cfg_error               <= 1'b0;
      acc                     <= '0;
    end else begin
      write_config_data <= pop && in_range;
      start_exec        <= (state == START);
      if (pop && in_range) begin
        config_PE_row_index     <= head.row;
        config_PE_column_index  <= head.col;
        config_input_PE_index_1 <= head.idx1;
        config_input_PE_index_2 <= head.idx2;
        config_op               <= head.op;
        config_const_data       <= head.cst;
        config_index            <= head.ctx;
      end
      if (pop && !in_range) cfg_error <= 1'b1;
      if (state == START) begin
        mapping_context_max_id <= acc;
        acc                    <= '0;
      end else if (pop && in_range && (head.ctx > acc)) begin
        acc <= head.ctx;
      end
    end
  end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Table-driven bench with an event scoreboard for cgra_config_loader.
// The row index is widened to 3 bits so out-of-range rows can be driven.
module tb_cgra_config_loader;
  localparam int RB = 3, CB = 2, IB = 3, OB = 4, DW = 32, XB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [RB-1:0] in_row;
  logic [CB-1:0] in_column;
  logic [IB-1:0] in_input_index_1, in_input_index_2;
  logic [OB-1:0] in_op;
  logic [DW-1:0] in_const;
  logic [XB-1:0] in_context;
  logic [RB-1:0] config_PE_row_index;
  logic [CB-1:0] config_PE_column_index;
  logic [IB-1:0] config_input_PE_index_1, config_input_PE_index_2;
  logic [OB-1:0] config_op;
  logic [DW-1:0] config_const_data;
  logic [XB-1:0] config_index, mapping_context_max_id;
  logic          write_config_data, start_exec, busy, cfg_error;

  cgra_config_loader #(.PE_ROW_BIT_LENGTH(RB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_column(in_column),
    .in_input_index_1(in_input_index_1), .in_input_index_2(in_input_index_2),
    .in_op(in_op), .in_const(in_const), .in_context(in_context), .in_last(in_last),
    .config_PE_row_index(config_PE_row_index), .config_PE_column_index(config_PE_column_index),
    .config_input_PE_index_1(config_input_PE_index_1),
    .config_input_PE_index_2(config_input_PE_index_2),
    .config_op(config_op), .config_const_data(config_const_data), .config_index(config_index),
    .write_config_data(write_config_data), .start_exec(start_exec),
    .mapping_context_max_id(mapping_context_max_id), .busy(busy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RB-1:0] row; logic [CB-1:0] col; logic [IB-1:0] i1, i2;
    logic [OB-1:0] op;  logic [DW-1:0] cst; logic [XB-1:0] ctx; logic last;
    logic exp_wr; logic [XB-1:0] exp_max;
  } vec_t;

  typedef struct {
    logic is_start;
    logic [RB-1:0] row; logic [CB-1:0] col; logic [IB-1:0] i1, i2;
    logic [OB-1:0] op;  logic [DW-1:0] cst; logic [XB-1:0] val;
  } ev_t;

  vec_t tbl [15];
  ev_t  sb [$];
  ev_t  e;
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cyc = 0, last_wr_cyc = 0, last_st_cyc = 0;
  int   wr_cnt = 0, st_cnt = 0, run = 0, max_run = 0;
  logic saw_full = 1'b0;

  function automatic vec_t mk(int row, int col, int i1, int i2, int op, logic [DW-1:0] cst,
                              int ctx, int last, int wr, int mx);
    vec_t v;
    v.row = RB'(row); v.col = CB'(col); v.i1 = IB'(i1); v.i2 = IB'(i2); v.op = OB'(op);
    v.cst = cst; v.ctx = XB'(ctx); v.last = 1'(last); v.exp_wr = 1'(wr); v.exp_max = XB'(mx);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!in_ready) saw_full = 1'b1;
    if (!reset && write_config_data) begin
      wr_cnt++; last_wr_cyc = cyc; run++;
      if (run > max_run) max_run = run;
      checks++;
      if (sb.size() == 0 || sb[0].is_start) begin
        errors++;
        $display("FAIL write_unexpected got write at cycle %0d expected %0s", cyc,
                 (sb.size() == 0) ? "nothing" : "start");
      end else begin
        e = sb.pop_front();
        if ({config_PE_row_index, config_PE_column_index, config_input_PE_index_1,
             config_input_PE_index_2, config_op, config_const_data, config_index} !==
            {e.row, e.col, e.i1, e.i2, e.op, e.cst, e.val}) begin
          errors++;
          $display("FAIL write_fields got r%0d c%0d i%0d/%0d op%0d k%0h x%0d expected r%0d c%0d i%0d/%0d op%0d k%0h x%0d",
                   config_PE_row_index, config_PE_column_index, config_input_PE_index_1,
                   config_input_PE_index_2, config_op, config_const_data, config_index,
                   e.row, e.col, e.i1, e.i2, e.op, e.cst, e.val);
        end
      end
    end else begin
      run = 0;
    end
    if (!reset && start_exec) begin
      st_cnt++; last_st_cyc = cyc;
      checks++;
      if (sb.size() == 0 || !sb[0].is_start) begin
        errors++;
        $display("FAIL start_unexpected got start at cycle %0d expected %0s", cyc,
                 (sb.size() == 0) ? "nothing" : "write");
      end else begin
        e = sb.pop_front();
        if (mapping_context_max_id !== e.val) begin
          errors++;
          $display("FAIL start_max_id got %0d expected %0d", mapping_context_max_id, e.val);
        end
      end
    end
  end

  // Drive one entry, wait for acceptance, and queue the expected events.
  task automatic send(input vec_t v);
    int  n;
    ev_t w;
    in_row = v.row; in_column = v.col; in_input_index_1 = v.i1; in_input_index_2 = v.i2;
    in_op = v.op; in_const = v.cst; in_context = v.ctx; in_last = v.last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (v.exp_wr) begin
      w.is_start = 1'b0; w.row = v.row; w.col = v.col; w.i1 = v.i1; w.i2 = v.i2;
      w.op = v.op; w.cst = v.cst; w.val = v.ctx;
      sb.push_back(w);
    end
    if (v.last) begin
      w = '{default: '0};
      w.is_start = 1'b1; w.val = v.exp_max;
      sb.push_back(w);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d busy=%0b expected pending=0 busy=0", tag, sb.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w0, s0;
    vec_t v;
    //            row col i1 i2 op const         ctx last wr max
    tbl[0]  = mk(1, 2, 0, 4, 3, 32'h55,        2,  1,  1, 2);
    tbl[1]  = mk(0, 0, 1, 2, 1, 32'h1000_0001, 0,  0,  1, 0);
    tbl[2]  = mk(1, 1, 2, 3, 2, 32'h2000_0002, 3,  0,  1, 0);
    tbl[3]  = mk(2, 2, 3, 4, 5, 32'h3000_0003, 1,  0,  1, 0);
    tbl[4]  = mk(3, 3, 4, 5, 6, 32'h4000_0004, 5,  0,  1, 0);
    tbl[5]  = mk(0, 3, 5, 6, 7, 32'h5000_0005, 2,  0,  1, 0);
    tbl[6]  = mk(3, 0, 6, 7, 8, 32'hDEAD_BEEF, 4,  1,  1, 5);
    tbl[7]  = mk(1, 0, 1, 1, 1, 32'h11,        1,  0,  1, 0);
    tbl[8]  = mk(2, 3, 2, 2, 2, 32'h22,        2,  0,  1, 0);
    tbl[9]  = mk(4, 1, 3, 3, 3, 32'h33,        7,  1,  0, 2);
    tbl[10] = mk(5, 0, 0, 0, 0, 32'h44,        9,  1,  0, 0);
    tbl[11] = mk(0, 0, 1, 2, 9, 32'hA0,        3,  0,  1, 0);
    tbl[12] = mk(3, 3, 2, 1, 10, 32'hA1,       1,  1,  1, 3);
    tbl[13] = mk(1, 1, 0, 7, 11, 32'hB0,       2,  0,  1, 0);
    tbl[14] = mk(2, 2, 7, 0, 12, 32'hB1,       0,  1,  1, 2);

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_row = '0; in_column = '0;
    in_input_index_1 = '0; in_input_index_2 = '0; in_op = '0; in_const = '0; in_context = '0;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_ctrl", {59'd0, write_config_data, start_exec, busy, cfg_error, 1'b0} | 64'(mapping_context_max_id), 64'd0);
    chk("reset_cfg", 64'(config_const_data) | 64'(config_index) | 64'(config_PE_row_index), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Single entry: write 1 cycle after acceptance edge, start one cycle later.
    w0 = wr_cnt;
    send(tbl[0]);
    wait_idle("single");
    chk("single_wr_latency", 64'(last_wr_cyc - acc_cyc), 64'd1);
    chk("single_st_latency", 64'(last_st_cyc - acc_cyc), 64'd2);
    chk("single_wr_count", 64'(wr_cnt - w0), 64'd1);
    chk("single_max_id", 64'(mapping_context_max_id), 64'd2);

    // Burst of six with valid held high.
    max_run = 0;
    for (int i = 1; i <= 6; i++) send(tbl[i]);
    wait_idle("burst");
    chk("burst_consecutive", 64'(max_run), 64'd6);
    chk("burst_max_id", 64'(mapping_context_max_id), 64'd5);

    // Out-of-range last entry after two good ones, then an all-dropped batch.
    for (int i = 7; i <= 9; i++) send(tbl[i]);
    wait_idle("bad");
    chk("bad_cfg_error", 64'(cfg_error), 64'd1);
    chk("bad_max_id", 64'(mapping_context_max_id), 64'd2);
    w0 = wr_cnt; s0 = st_cnt;
    send(tbl[10]);
    wait_idle("empty_batch");
    chk("empty_batch_writes", 64'(wr_cnt - w0), 64'd0);
    chk("empty_batch_starts", 64'(st_cnt - s0), 64'd1);
    chk("empty_batch_max_id", 64'(mapping_context_max_id), 64'd0);

    // Two back-to-back batches; the second is pushed while the first closes.
    for (int i = 11; i <= 14; i++) send(tbl[i]);
    wait_idle("two_batches");
    chk("two_batches_max_id", 64'(mapping_context_max_id), 64'd2);
    chk("cfg_error_sticky", 64'(cfg_error), 64'd1);

    // Pointer wrap: 20 single-entry batches; START pauses let the FIFO fill.
    saw_full = 1'b0; w0 = wr_cnt; s0 = st_cnt;
    for (int i = 0; i < 20; i++) begin
      v = mk(i % 4, (i / 4) % 4, i % 8, (i + 3) % 8, i % 16, $urandom, i % 16, 1, 1, i % 16);
      send(v);
    end
    wait_idle("wrap");
    chk("wrap_writes", 64'(wr_cnt - w0), 64'd20);
    chk("wrap_starts", 64'(st_cnt - s0), 64'd20);
    chk("wrap_saw_full", 64'(saw_full), 64'd1);

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 4; i++) begin
      v = mk(1, 1, 1, 1, 1, 32'h77, i + 1, 1, 1, i + 1);
      send(v);
    end
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {60'd0, write_config_data, start_exec, busy, cfg_error}, 64'd0);
    chk("async_rst_max_id", 64'(mapping_context_max_id), 64'd0);
    chk("async_rst_cfg", 64'(config_const_data) | 64'(config_index) | 64'(config_op), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt; s0 = st_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("post_rst_no_starts", 64'(st_cnt - s0), 64'd0);
    send(tbl[0]);
    wait_idle("post_rst");
    chk("post_rst_max_id", 64'(mapping_context_max_id), 64'd2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
